// File: rtl/instr_realigner.sv
// Realigns word-aligned 32-bit fetch words into whole RV32C/RV32 instructions with per-instruction PCs.
// Compressed halfwords are issued zero-extended; 32-bit instructions may straddle two fetch words.
module instr_realigner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_data_i,
    output logic        fetch_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic        out_compressed_o
);

    typedef enum logic [1:0] {
        StAligned,
        StHalf,
        StSkipLow
    } state_e;

    state_e      state_q;
    logic [15:0] hw_buf_q;
    logic [31:0] cur_pc_q;

    logic w_comp;
    logic h_comp;
    logic accept;
    logic unused_flush_lsb;

    assign w_comp           = fetch_data_i[1:0] != 2'b11;
    assign h_comp           = hw_buf_q[1:0] != 2'b11;
    assign out_pc_o         = cur_pc_q;
    assign accept           = out_valid_o & out_ready_i;
    assign unused_flush_lsb = flush_pc_i[0];

    always_comb begin
        out_valid_o      = 1'b0;
        fetch_ready_o    = 1'b0;
        out_instr_o      = fetch_data_i;
        out_compressed_o = 1'b0;
        case (state_q)
            StAligned: begin
                out_valid_o      = fetch_valid_i;
                out_compressed_o = w_comp;
                out_instr_o      = w_comp ? {16'h0000, fetch_data_i[15:0]} : fetch_data_i;
                fetch_ready_o    = fetch_valid_i & out_ready_i;
            end
            StHalf: begin
                if (h_comp) begin
                    // Buffered halfword is a whole instruction; no fetch word needed.
                    out_valid_o      = 1'b1;
                    out_compressed_o = 1'b1;
                    out_instr_o      = {16'h0000, hw_buf_q};
                end else begin
                    out_valid_o   = fetch_valid_i;
                    out_instr_o   = {fetch_data_i[15:0], hw_buf_q};
                    fetch_ready_o = fetch_valid_i & out_ready_i;
                end
            end
            StSkipLow: begin
                fetch_ready_o = fetch_valid_i;
            end
            default: ;
        endcase
        if (reset || flush_i) begin
            out_valid_o   = 1'b0;
            fetch_ready_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StAligned;
            hw_buf_q <= 16'h0000;
            cur_pc_q <= RESET_PC;
        end else if (flush_i) begin
            state_q  <= flush_pc_i[1] ? StSkipLow : StAligned;
            hw_buf_q <= 16'h0000;
            cur_pc_q <= {flush_pc_i[31:1], 1'b0};
        end else begin
            case (state_q)
                StAligned: begin
                    if (accept) begin
                        if (w_comp) begin
                            hw_buf_q <= fetch_data_i[31:16];
                            state_q  <= StHalf;
                            cur_pc_q <= cur_pc_q + 32'd2;
                        end else begin
                            cur_pc_q <= cur_pc_q + 32'd4;
                        end
                    end
                end
                StHalf: begin
                    if (accept) begin
                        if (h_comp) begin
                            state_q  <= StAligned;
                            cur_pc_q <= cur_pc_q + 32'd2;
                        end else begin
                            hw_buf_q <= fetch_data_i[31:16];
                            cur_pc_q <= cur_pc_q + 32'd4;
                        end
                    end
                end
                StSkipLow: begin
                    // Low halfword lies before the redirect target and is dropped.
                    if (fetch_valid_i) begin
                        hw_buf_q <= fetch_data_i[31:16];
                        state_q  <= StHalf;
                    end
                end
                default: state_q <= StAligned;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_realigner.sv
// Scoreboard bench for instr_realigner: fetch words come from a queue, expected
// instructions are queued with the stimulus and compared on every output handshake.
module tb_instr_realigner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = 32'h0;
    logic        fetch_valid_i = 1'b0;
    logic [31:0] fetch_data_i = 32'h0;
    logic        fetch_ready_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_compressed_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fetch_q[$];

    always #5 clk = ~clk;

    instr_realigner #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_data_i    (fetch_data_i),
        .fetch_ready_o   (fetch_ready_o),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_instr_o     (out_instr_o),
        .out_pc_o        (out_pc_o),
        .out_compressed_o(out_compressed_o)
    );

    // Fetch model: presents the head of fetch_q shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        fetch_valid_i = fetch_q.size() > 0;
        fetch_data_i  = (fetch_q.size() > 0) ? fetch_q[0] : 32'h0;
    end

    // Output monitor and fetch consumption, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid_o && out_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got instr=%h pc=%h, required no output",
                         out_instr_o, out_pc_o);
            end else begin
                e = exp_q.pop_front();
                if (out_instr_o !== e.instr || out_pc_o !== e.pc || out_compressed_o !== e.comp) begin
                    errors++;
                    $display("FAIL scoreboard: got instr=%h pc=%h c=%b, required instr=%h pc=%h c=%b",
                             out_instr_o, out_pc_o, out_compressed_o, e.instr, e.pc, e.comp);
                end
            end
        end
        if (!reset && fetch_valid_i && fetch_ready_o && fetch_q.size() > 0)
            void'(fetch_q.pop_front());
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc, input logic comp);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.comp  = comp;
        exp_q.push_back(e);
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush_i    = 1'b1;
        flush_pc_i = pc;
        cycle();
        flush_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            cycle();
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d instructions outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_aligned();
        repeat (2) cycle();
        fetch_q.push_back(32'h0000_0013);
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: valid=%b ready=%b, required 0 0", out_valid_o, fetch_ready_o);
        end
        cycle();
        reset = 1'b0;
        push_exp(32'h0000_0013, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b1 || out_pc_o !== 32'h0 || fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL aligned32: valid=%b pc=%h ready=%b, required 1 00000000 1",
                     out_valid_o, out_pc_o, fetch_ready_o);
        end
        cycle();
        wait_drain();
    endtask

    task automatic test_two_compressed();
        fetch_q.push_back(32'h4501_4485);
        do_flush(32'h0);
        push_exp(32'h0000_4485, 32'h0, 1'b1);
        push_exp(32'h0000_4501, 32'h2, 1'b1);
        @(negedge clk);
        checks++;
        if (fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL two_c_consume: ready=%b, required 1", fetch_ready_o);
        end
        cycle();
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b1 || fetch_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL two_c_second: valid=%b ready=%b, required 1 0", out_valid_o, fetch_ready_o);
        end
        cycle();
        wait_drain();
    endtask

    task automatic test_straddle();
        fetch_q.push_back(32'h0013_4501);
        fetch_q.push_back(32'h4505_0000);
        do_flush(32'h200);
        push_exp(32'h0000_4501, 32'h200, 1'b1);
        push_exp(32'h0000_0013, 32'h202, 1'b0);
        push_exp(32'h0000_4505, 32'h206, 1'b1);
        wait_drain();
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL straddle_idle: valid=%b, required 0", out_valid_o);
        end
        cycle();
    endtask

    task automatic test_odd_flush();
        fetch_q.push_back(32'h4505_0001);
        flush_i    = 1'b1;
        flush_pc_i = 32'h103;
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_quiet: valid=%b ready=%b, required 0 0", out_valid_o, fetch_ready_o);
        end
        cycle();
        flush_i = 1'b0;
        push_exp(32'h0000_4505, 32'h102, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL skip_bubble: valid=%b ready=%b, required 0 1", out_valid_o, fetch_ready_o);
        end
        cycle();
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b1 || out_pc_o !== 32'h102) begin
            errors++;
            $display("FAIL skip_issue: valid=%b pc=%h, required 1 00000102", out_valid_o, out_pc_o);
        end
        cycle();
        wait_drain();
    endtask

    task automatic test_backpressure();
        fetch_q.push_back(32'h0013_4501);
        fetch_q.push_back(32'h4505_0000);
        do_flush(32'h300);
        push_exp(32'h0000_4501, 32'h300, 1'b1);
        push_exp(32'h0000_0013, 32'h302, 1'b0);
        push_exp(32'h0000_4505, 32'h306, 1'b1);
        cycle();
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid_o !== 1'b1 || out_instr_o !== 32'h13 || out_pc_o !== 32'h302 ||
                fetch_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL backpressure[%0d]: valid=%b instr=%h pc=%h ready=%b, required 1 00000013 00000302 0",
                         i, out_valid_o, out_instr_o, out_pc_o, fetch_ready_o);
            end
            cycle();
        end
        out_ready_i = 1'b1;
        wait_drain();
    endtask

    task automatic test_wrap();
        fetch_q.push_back(32'h4501_4485);
        fetch_q.push_back(32'h0000_0013);
        do_flush(32'hFFFF_FFFC);
        push_exp(32'h0000_4485, 32'hFFFF_FFFC, 1'b1);
        push_exp(32'h0000_4501, 32'hFFFF_FFFE, 1'b1);
        push_exp(32'h0000_0013, 32'h0000_0000, 1'b0);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        fetch_q.push_back(32'h0013_4501);
        do_flush(32'h400);
        push_exp(32'h0000_4501, 32'h400, 1'b1);
        wait_drain();
        // Straddle pending in HALF; reset and flush arrive together.
        fetch_q.push_back(32'h0000_0013);
        reset      = 1'b1;
        flush_i    = 1'b1;
        flush_pc_i = 32'h503;
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: valid=%b ready=%b, required 0 0", out_valid_o, fetch_ready_o);
        end
        cycle();
        reset   = 1'b0;
        flush_i = 1'b0;
        push_exp(32'h0000_0013, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b1 || out_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_wins: valid=%b pc=%h, required 1 00000000", out_valid_o, out_pc_o);
        end
        cycle();
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [15:0] hws[$];
        logic [31:0] pc;
        logic [31:0] r;
        logic [31:0] ins;
        int unsigned lo;
        int          n;
        pc = 32'h1000;
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                lo = $urandom_range(0, 2);
                hws.push_back({r[15:2], lo[1:0]});
                push_exp({16'h0000, r[15:2], lo[1:0]}, pc, 1'b1);
                pc = pc + 32'd2;
            end else begin
                ins = {r[31:2], 2'b11};
                hws.push_back(ins[15:0]);
                hws.push_back(ins[31:16]);
                push_exp(ins, pc, 1'b0);
                pc = pc + 32'd4;
            end
        end
        if (hws.size() % 2 == 1) begin
            hws.push_back(16'h0001);
            push_exp(32'h0000_0001, pc, 1'b1);
        end
        for (int k = 0; k < hws.size(); k += 2)
            fetch_q.push_back({hws[k+1], hws[k]});
        do_flush(32'h1000);
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            out_ready_i = ($urandom_range(0, 3) != 0);
            cycle();
            n++;
        end
        out_ready_i = 1'b1;
        wait_drain();
        checks++;
        if (fetch_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_words_left: %0d words unconsumed, required 0", fetch_q.size());
        end
    endtask

    initial begin
        test_reset_aligned();
        test_two_compressed();
        test_straddle();
        test_odd_flush();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
